uart_txrx: RTL and testbench
============================

// Module: uart_txrx
// PURPOSE
//  8N1 UART transceiver: one transmitter and one receiver sharing a clock, reset and bit timing.
//  Serialises a byte on a one-cycle strobe; deserialises an incoming frame into a byte plus a
//  one-cycle valid pulse. Sits between a parallel byte interface and the board serial pins.
// PARAMETERS
//  CLKS_PER_BIT  217  clocks per serial bit (clock/baud, e.g. 25 MHz / 115200); legal >= 4
// PORTS
//  i_Clock      in   1  system clock, all logic on rising edge
//  i_Rst_n      in   1  reset; asynchronous, active-low
//  i_TX_DV      in   1  one-cycle strobe: start transmitting i_TX_Byte
//  i_TX_Byte    in   8  byte to send, sampled on the cycle i_TX_DV is high
//  o_TX_Active  out  1  high while a frame is being driven
//  o_TX_Serial  out  1  serial out, idle high
//  o_TX_Done    out  1  one-cycle pulse at end of stop bit
//  i_RX_Serial  in   1  serial in, asynchronous to i_Clock, idle high
//  o_RX_DV      out  1  one-cycle pulse: o_RX_Byte valid
//  o_RX_Byte    out  8  last received byte, held until the next frame completes
// BEHAVIOUR
//  - Reset: o_TX_Serial=1, o_TX_Active=0, o_TX_Done=0, o_RX_DV=0, o_RX_Byte=0, both FSMs IDLE.
//    Reset mid-frame aborts the frame immediately; no partial byte or pulse is produced.
//  - Frame: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); each bit CLKS_PER_BIT clocks.
//  - TX FSM IDLE->START->DATA->STOP->CLEANUP->IDLE.
//    IDLE: line high; i_TX_DV=1 latches the byte and enters START; o_TX_Active=1 from next cycle.
//    START/DATA/STOP: drive bit for CLKS_PER_BIT clocks; a 3-bit index counts data bits 0..7.
//    End of STOP: o_TX_Done=1 for one cycle, o_TX_Active=0 in that same cycle; CLEANUP lasts 1 clock.
//    i_TX_DV while not IDLE is ignored; back-to-back strobes are accepted from IDLE.
//  - RX: i_RX_Serial is passed through a 2-flop synchroniser before any use.
//    RX FSM IDLE->START->DATA->STOP->CLEANUP->IDLE.
//    IDLE: synchronised low moves to START.
//    START: at (CLKS_PER_BIT-1)/2 clocks, sample again; still low -> DATA, else glitch -> IDLE.
//    DATA: sample each bit CLKS_PER_BIT clocks after the previous sample (mid-bit), shift into
//    bit index 0..7.
//    STOP: wait CLKS_PER_BIT clocks, then o_RX_Byte updates and o_RX_DV=1 for exactly one cycle.
//    CLEANUP: 1 clock, then IDLE.
//  - Counters are sized $clog2(CLKS_PER_BIT); they reset to 0 on every state change.
//  - TX and RX are independent; a simultaneous TX start and RX completion does not interact.
// CONFIGURATION
//  UART_FRAMING_CHECK_EN defined: RX samples the stop bit at mid-bit.
//    If the stop bit is 0, o_RX_DV is suppressed and a one-cycle pulse appears on extra output
//    o_RX_Frame_Err (1 bit, reset 0); o_RX_Byte is not updated.
//  Not defined: the stop bit value is ignored and o_RX_Frame_Err does not exist.
// STRUCTURE
//  Package uart_pkg: DATA_BITS=8 and typedef enum uart_state_t {IDLE,START,DATA,STOP,CLEANUP}.
//  Sub-module uart_bit_timer: counter with a terminal-count flag, instantiated once each by TX and RX.
//  All other logic is inline.
// TESTING (loopback: i_RX_Serial = o_TX_Active ? o_TX_Serial : 1, CLKS_PER_BIT=217, 40 ns clock)
//  - Pulse i_TX_DV with 0x2F -> o_RX_DV pulses once, o_RX_Byte=0x2F.
//    o_TX_Done pulses 10*217+1 clocks after the strobe.
//  - Send 0x00, then 0xFF and 0x55 back-to-back -> each byte is received in order.
//    Check the line waveform bit by bit, LSB first.
//  - Drive a low glitch of 50 clocks on i_RX_Serial -> no o_RX_DV; RX returns to IDLE.
//  - Assert i_TX_DV mid-frame -> ignored, frame unchanged.
//    Reset mid-frame -> outputs return to reset values.
//  - With UART_FRAMING_CHECK_EN, inject stop bit=0 -> o_RX_Frame_Err pulses, no o_RX_DV.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the uart_txrx transceiver.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        CLEANUP
    } uart_state_t;

endpackage

// File: rtl/uart_txrx_if.sv
// Byte-side and serial-side signals of the transceiver, bundled for port connection.
// UART_FRAMING_CHECK_EN adds the o_RX_Frame_Err pulse.
interface uart_txrx_if;

    logic       i_TX_DV;
    logic [7:0] i_TX_Byte;
    logic       o_TX_Active;
    logic       o_TX_Serial;
    logic       o_TX_Done;
    logic       i_RX_Serial;
    logic       o_RX_DV;
    logic [7:0] o_RX_Byte;
`ifdef UART_FRAMING_CHECK_EN
    logic       o_RX_Frame_Err;
`endif

    modport master (
        output i_TX_DV, i_TX_Byte, i_RX_Serial,
        input  o_TX_Active, o_TX_Serial, o_TX_Done, o_RX_DV, o_RX_Byte
`ifdef UART_FRAMING_CHECK_EN
        , input o_RX_Frame_Err
`endif
    );

    modport slave (
        input  i_TX_DV, i_TX_Byte, i_RX_Serial,
        output o_TX_Active, o_TX_Serial, o_TX_Done, o_RX_DV, o_RX_Byte
`ifdef UART_FRAMING_CHECK_EN
        , output o_RX_Frame_Err
`endif
    );

endinterface

// File: rtl/uart_bit_timer.sv
// Free-running bit-period counter: held at zero by clr_i, wraps to zero on reaching limit_i,
// and flags that terminal count for one cycle.
module uart_bit_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] limit_i,
    output logic             tc_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    assign tc_o = (cnt_q == limit_i);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr_i || tc_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_txrx.sv
// 8N1 UART transmitter and receiver sharing one clock and bit timing.
// Define UART_FRAMING_CHECK_EN to reject frames whose stop bit samples low.
module uart_txrx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic        i_Clock,
    input  logic        i_Rst_n,
    uart_txrx_if.slave  bus
);

    localparam int              CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]   BIT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   HALF_BIT = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [2:0]      IDX_LAST = 3'(DATA_BITS - 1);

    // ---------------- transmitter ----------------
    uart_state_t tx_state_q;
    logic [7:0]  tx_byte_q;
    logic [2:0]  tx_idx_q;
    logic        tx_serial_q;
    logic        tx_active_q;
    logic        tx_done_q;
    logic        tx_tc;
    logic        tx_clr;

    assign tx_clr = (tx_state_q == IDLE) || (tx_state_q == CLEANUP);

    uart_bit_timer #(.WIDTH(CW)) u_tx_timer (
        .clk_i   (i_Clock),
        .rst_ni  (i_Rst_n),
        .clr_i   (tx_clr),
        .limit_i (BIT_LAST),
        .tc_o    (tx_tc)
    );

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            tx_state_q  <= IDLE;
            tx_byte_q   <= '0;
            tx_idx_q    <= '0;
            tx_serial_q <= 1'b1;
            tx_active_q <= 1'b0;
            tx_done_q   <= 1'b0;
        end else begin
            tx_done_q <= 1'b0;
            case (tx_state_q)
                IDLE: begin
                    tx_serial_q <= 1'b1;
                    tx_idx_q    <= '0;
                    if (bus.i_TX_DV) begin
                        tx_byte_q   <= bus.i_TX_Byte;
                        tx_serial_q <= 1'b0;
                        tx_active_q <= 1'b1;
                        tx_state_q  <= START;
                    end
                end
                START: if (tx_tc) begin
                    tx_serial_q <= tx_byte_q[0];
                    tx_state_q  <= DATA;
                end
                DATA: if (tx_tc) begin
                    if (tx_idx_q == IDX_LAST) begin
                        tx_serial_q <= 1'b1;
                        tx_state_q  <= STOP;
                    end else begin
                        tx_idx_q    <= tx_idx_q + 3'd1;
                        tx_serial_q <= tx_byte_q[tx_idx_q + 3'd1];
                    end
                end
                STOP: if (tx_tc) begin
                    tx_done_q   <= 1'b1;
                    tx_active_q <= 1'b0;
                    tx_state_q  <= CLEANUP;
                end
                CLEANUP: tx_state_q <= IDLE;
                default: tx_state_q <= IDLE;
            endcase
        end
    end

    assign bus.o_TX_Serial = tx_serial_q;
    assign bus.o_TX_Active = tx_active_q;
    assign bus.o_TX_Done   = tx_done_q;

    // ---------------- receiver ----------------
    uart_state_t   rx_state_q;
    logic          rx_meta_q;
    logic          rx_sync_q;
    logic [7:0]    rx_shift_q;
    logic [7:0]    rx_byte_q;
    logic [2:0]    rx_idx_q;
    logic          rx_dv_q;
    logic          rx_tc;
    logic          rx_clr;
    logic [CW-1:0] rx_limit;

    assign rx_clr   = (rx_state_q == IDLE) || (rx_state_q == CLEANUP);
    // First sample lands mid start bit; every later sample is one full bit further on.
    assign rx_limit = (rx_state_q == START) ? HALF_BIT : BIT_LAST;

    uart_bit_timer #(.WIDTH(CW)) u_rx_timer (
        .clk_i   (i_Clock),
        .rst_ni  (i_Rst_n),
        .clr_i   (rx_clr),
        .limit_i (rx_limit),
        .tc_o    (rx_tc)
    );

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= bus.i_RX_Serial;
            rx_sync_q <= rx_meta_q;
        end
    end

`ifdef UART_FRAMING_CHECK_EN
    logic rx_err_q;
    assign bus.o_RX_Frame_Err = rx_err_q;
`endif

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            rx_state_q <= IDLE;
            rx_shift_q <= '0;
            rx_byte_q  <= '0;
            rx_idx_q   <= '0;
            rx_dv_q    <= 1'b0;
`ifdef UART_FRAMING_CHECK_EN
            rx_err_q   <= 1'b0;
`endif
        end else begin
            rx_dv_q <= 1'b0;
`ifdef UART_FRAMING_CHECK_EN
            rx_err_q <= 1'b0;
`endif
            case (rx_state_q)
                IDLE: begin
                    rx_idx_q <= '0;
                    if (!rx_sync_q) begin
                        rx_state_q <= START;
                    end
                end
                START: if (rx_tc) begin
                    rx_state_q <= rx_sync_q ? IDLE : DATA;
                end
                DATA: if (rx_tc) begin
                    rx_shift_q[rx_idx_q] <= rx_sync_q;
                    if (rx_idx_q == IDX_LAST) begin
                        rx_state_q <= STOP;
                    end else begin
                        rx_idx_q <= rx_idx_q + 3'd1;
                    end
                end
                STOP: if (rx_tc) begin
`ifdef UART_FRAMING_CHECK_EN
                    if (rx_sync_q) begin
                        rx_byte_q <= rx_shift_q;
                        rx_dv_q   <= 1'b1;
                    end else begin
                        rx_err_q  <= 1'b1;
                    end
`else
                    rx_byte_q <= rx_shift_q;
                    rx_dv_q   <= 1'b1;
`endif
                    rx_state_q <= CLEANUP;
                end
                CLEANUP: rx_state_q <= IDLE;
                default: rx_state_q <= IDLE;
            endcase
        end
    end

    assign bus.o_RX_DV   = rx_dv_q;
    assign bus.o_RX_Byte = rx_byte_q;

endmodule

// File: tb/tb_uart_txrx.sv
// Loopback bench for uart_txrx: random and directed bytes against a frame-level reference model.
module tb_uart_txrx;

    localparam int CPB        = 217;
    localparam int FRAME_CLKS = 10 * CPB;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic bb_en   = 1'b0;
    logic bb_line = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];

    uart_txrx_if bus ();

    assign bus.i_RX_Serial = bb_en ? bb_line : (bus.o_TX_Active ? bus.o_TX_Serial : 1'b1);

    uart_txrx #(.CLKS_PER_BIT(CPB)) dut (
        .i_Clock (clk),
        .i_Rst_n (rst_n),
        .bus     (bus.slave)
    );

    always #20 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bit k of an 8N1 frame as it should appear on the line.
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return b[k-1];
    endfunction

    task automatic watch(input int cycles, output int dv_cnt, output int done_cnt, output int err_cnt);
        dv_cnt = 0; done_cnt = 0; err_cnt = 0;
        repeat (cycles) begin
            @(posedge clk); #1;
            if (bus.o_RX_DV)   dv_cnt++;
            if (bus.o_TX_Done) done_cnt++;
`ifdef UART_FRAMING_CHECK_EN
            if (bus.o_RX_Frame_Err) err_cnt++;
`endif
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit inject_dv);
        int n = 0;
        int done_at = 0;
        int dv_cnt = 0;
        int err_cnt = 0;
        logic [7:0] rx_got = 8'h00;
        exp_q.push_back(b);
        bus.i_TX_Byte = b;
        bus.i_TX_DV   = 1'b1;
        while (done_at == 0 && n < FRAME_CLKS + 100) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) begin
                bus.i_TX_DV   = 1'b0;
                bus.i_TX_Byte = 8'h00;
                check("tx_active_start", 32'(bus.o_TX_Active), 32'd1);
            end
            if (inject_dv && n == 3 * CPB) begin
                bus.i_TX_DV   = 1'b1;
                bus.i_TX_Byte = ~b;
            end
            if (inject_dv && n == 3 * CPB + 1) bus.i_TX_DV = 1'b0;
            if ((n % CPB) == CPB / 2 + 1 && (n / CPB) < 10)
                check($sformatf("line_bit%0d", n / CPB), 32'(bus.o_TX_Serial), 32'(frame_bit(b, n / CPB)));
            if (bus.o_RX_DV) begin
                dv_cnt++;
                rx_got = bus.o_RX_Byte;
            end
`ifdef UART_FRAMING_CHECK_EN
            if (bus.o_RX_Frame_Err) err_cnt++;
`endif
            if (bus.o_TX_Done) done_at = n;
        end
        check("tx_done_latency", 32'(done_at), 32'(FRAME_CLKS + 1));
        check("tx_active_at_done", 32'(bus.o_TX_Active), 32'd0);
        check("rx_dv_count", 32'(dv_cnt), 32'd1);
        check("rx_frame_err_count", 32'(err_cnt), 32'd0);
        check("rx_byte", 32'(rx_got), 32'(exp_q.pop_front()));
        $display("frame tx=0x%02h rx=0x%02h done_after=%0d inject=%0d", b, rx_got, done_at, inject_dv);
        @(posedge clk); #1;
        check("tx_done_one_cycle", 32'(bus.o_TX_Done), 32'd0);
        check("rx_byte_held", 32'(bus.o_RX_Byte), 32'(b));
    endtask

    initial begin
        int dv_cnt, done_cnt, err_cnt;
        bus.i_TX_DV   = 1'b0;
        bus.i_TX_Byte = 8'h00;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_serial", 32'(bus.o_TX_Serial), 32'd1);
        check("rst_tx_active", 32'(bus.o_TX_Active), 32'd0);
        check("rst_tx_done",   32'(bus.o_TX_Done),   32'd0);
        check("rst_rx_dv",     32'(bus.o_RX_DV),     32'd0);
        check("rst_rx_byte",   32'(bus.o_RX_Byte),   32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        send_frame(8'h2F, 1'b0);
        send_frame(8'h00, 1'b0);
        send_frame(8'hFF, 1'b0);
        send_frame(8'h55, 1'b0);
        for (int i = 0; i < 6; i++) send_frame(8'($urandom_range(0, 255)), 1'b0);

        send_frame(8'hC3, 1'b1);

        // Short low glitch must be rejected at the mid-start-bit sample.
        bb_en   = 1'b1;
        bb_line = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        bb_line = 1'b1;
        watch(FRAME_CLKS + 200, dv_cnt, done_cnt, err_cnt);
        check("glitch_no_rx_dv", 32'(dv_cnt), 32'd0);
        $display("glitch 50 clocks rx_dv_pulses=%0d", dv_cnt);
        bb_en = 1'b0;
        send_frame(8'h81, 1'b0);

        send_frame(8'hA7, 1'b0);
        bus.i_TX_Byte = 8'h3C;
        bus.i_TX_DV   = 1'b1;
        @(posedge clk); #1;
        bus.i_TX_DV   = 1'b0;
        repeat (1000) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_tx_serial", 32'(bus.o_TX_Serial), 32'd1);
        check("midrst_tx_active", 32'(bus.o_TX_Active), 32'd0);
        check("midrst_tx_done",   32'(bus.o_TX_Done),   32'd0);
        check("midrst_rx_dv",     32'(bus.o_RX_DV),     32'd0);
        check("midrst_rx_byte",   32'(bus.o_RX_Byte),   32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        watch(FRAME_CLKS + 200, dv_cnt, done_cnt, err_cnt);
        check("midrst_no_rx_dv",   32'(dv_cnt),   32'd0);
        check("midrst_no_tx_done", 32'(done_cnt), 32'd0);
        check("midrst_line_idle",  32'(bus.o_TX_Serial), 32'd1);
        $display("reset mid-frame rx_dv_pulses=%0d tx_done_pulses=%0d", dv_cnt, done_cnt);
        send_frame(8'h5A, 1'b0);

`ifdef UART_FRAMING_CHECK_EN
        begin
            int dv_sum = 0;
            int err_sum = 0;
            logic [7:0] bad_b = 8'hA5;
            logic [7:0] good_b = 8'h96;
            bb_en = 1'b1;
            for (int k = 0; k < 9; k++) begin
                bb_line = frame_bit(bad_b, k);
                watch(CPB, dv_cnt, done_cnt, err_cnt);
                dv_sum += dv_cnt; err_sum += err_cnt;
            end
            bb_line = 1'b0;
            watch(130, dv_cnt, done_cnt, err_cnt);
            dv_sum += dv_cnt; err_sum += err_cnt;
            bb_line = 1'b1;
            watch(400, dv_cnt, done_cnt, err_cnt);
            dv_sum += dv_cnt; err_sum += err_cnt;
            check("ferr_pulse_count", 32'(err_sum), 32'd1);
            check("ferr_no_rx_dv", 32'(dv_sum), 32'd0);
            check("ferr_byte_kept", 32'(bus.o_RX_Byte), 32'h5A);
            $display("bad stop frame 0x%02h frame_err=%0d rx_dv=%0d", bad_b, err_sum, dv_sum);
            dv_sum = 0; err_sum = 0;
            for (int k = 0; k < 10; k++) begin
                bb_line = frame_bit(good_b, k);
                watch(CPB, dv_cnt, done_cnt, err_cnt);
                dv_sum += dv_cnt; err_sum += err_cnt;
            end
            watch(200, dv_cnt, done_cnt, err_cnt);
            dv_sum += dv_cnt; err_sum += err_cnt;
            check("good_rx_dv", 32'(dv_sum), 32'd1);
            check("good_no_ferr", 32'(err_sum), 32'd0);
            check("good_rx_byte", 32'(bus.o_RX_Byte), 32'(good_b));
            $display("good stop frame 0x%02h frame_err=%0d rx_dv=%0d", good_b, err_sum, dv_sum);
            bb_en = 1'b0;
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #(40 * 100000);
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
